// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//   Byte-serial multi-precision add/subtract controller. One shared 8-bit
//   ripple adder (FA_8_bit) is stepped over the operands one byte per cycle,
//   least-significant byte first. The carry between bytes is held in a
//   register. Subtraction is A + ~B + 1: B is inverted on capture and the
//   carry register is seeded with 1.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   op_sub, op_a, op_b           : operation and operands, sampled on accept
//   res_valid/res_ready          : result handshake (valid only in DONE)
//   res_sum, res_carry, res_overflow : result, final carry (1 = no borrow
//                                  on subtract), signed overflow
// -----------------------------------------------------------------------------

module FA_8_bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 8; g++) begin : g_bit
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[8];

endmodule

module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_carry,
  output logic                  res_overflow
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;       // B, already inverted for subtract
  logic [W-1:0]      r_sum;
  logic              r_carry;   // inter-byte carry
  logic              r_res_carry;
  logic              r_res_ovf;
  logic [IDX_W-1:0]  r_idx;

  logic [7:0]        w_a_byte;
  logic [7:0]        w_b_byte;
  logic [7:0]        w_fa_sum;
  logic              w_fa_cout;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

  FA_8_bit u_fa (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; handshake outputs decode from state alone
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture: no reset needed, always loaded before use
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= op_a;
      r_b <= op_sub ? ~op_b : op_b;
    end
  end

  // Byte sequencing and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_res_carry <= 1'b0;
      r_res_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= op_sub;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 3'b000} +: 8] <= w_fa_sum;
      r_carry                     <= w_fa_cout;
      if (w_last) begin
        r_res_carry <= w_fa_cout;
        // Same-sign operands producing an opposite-sign result
        r_res_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_fa_sum[7] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign res_sum      = r_sum;
  assign res_carry    = r_res_carry;
  assign res_overflow = r_res_ovf;

endmodule
